// File: rtl/lcd_if_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_if_ctrl_if -- host-side write port of the LCD interface controller.
//
// The host (master) presents {wr_rs, wr_data} with wr_valid; the controller
// (slave) accepts when wr_ready is high and reports busy / fifo_count.
//
//   wr_valid    master -> slave  host presents a word
//   wr_rs       master -> slave  0 = instruction, 1 = display data
//   wr_data     master -> slave  8-bit word
//   wr_ready    slave -> master  FIFO can accept a word this cycle
//   busy        slave -> master  FIFO non-empty or transfer/wait in progress
//   fifo_count  slave -> master  current FIFO occupancy
// ---------------------------------------------------------------------------
interface lcd_if_ctrl_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_valid;
  logic             wr_ready;
  logic             wr_rs;
  logic [7:0]       wr_data;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output wr_valid, wr_rs, wr_data,
    input  wr_ready, busy, fifo_count
  );

  modport slave (
    input  wr_valid, wr_rs, wr_data,
    output wr_ready, busy, fifo_count
  );
endinterface

// File: rtl/lcd_if_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_if_ctrl -- write-only HD44780-style LCD bus controller.
//
// Host words are queued in a small FIFO and replayed onto the LCD bus with
// programmable setup / enable / hold timing, followed by a command execution
// wait (long wait for Clear/Home). 4-bit mode sends each word as two nibbles
// on LCD[7:4].
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   host    lcd_if_ctrl_if.slave (wr_valid/wr_ready/wr_rs/wr_data, busy,
//           fifo_count)
//   LCD     LCD data bus (registered)
//   lcdRS   register select (registered)
//   lcdRW   read/write, tied low (write-only)
//   lcdEn   enable strobe (registered, glitch-free)
//
// Parameter legality (not checked in hardware): DATA_MODE in {4, 8};
// FIFO_DEPTH a power of 2 >= 2; all *_CYCLES >= 1.
// ---------------------------------------------------------------------------
module lcd_if_ctrl #(
  parameter int DATA_MODE    = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 12,
  parameter int HOLD_CYCLES  = 2,
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic         clk,
  input  logic         reset,
  lcd_if_ctrl_if.slave host,
  output logic [7:0]   LCD,
  output logic         lcdRS,
  output logic         lcdRW,
  output logic         lcdEn
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One down-counter times every state, so it must hold the longest phase.
  localparam int MAX_W  = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int MAX_SE = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_SH = (MAX_SE > HOLD_CYCLES) ? MAX_SE : HOLD_CYCLES;
  localparam int MAX_T  = (MAX_W > MAX_SH) ? MAX_W : MAX_SH;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] EN_LD    = TMR_W'(EN_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(EXEC_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLEAR_LD = TMR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic [8:0]       head;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not open a full FIFO.
  assign host.wr_ready   = (count < CNT_W'(FIFO_DEPTH));
  assign host.fifo_count = count;
  assign push            = host.wr_valid && host.wr_ready;
  assign head            = mem[rptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;   // power-of-2 depth: natural wrap
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;                     // idle, or push+pop leaves count
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, and
  // leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {host.wr_rs, host.wr_data};
  end

  // ---------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             beat_q, beat_d;    // 0 = first beat, 1 = second nibble
  logic [8:0]       cur_q, cur_d;      // word in flight {rs, data}
  logic [7:0]       lcd_q, lcd_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             tmr_zero;
  logic             is_clear;

  function automatic logic [7:0] first_beat(input logic [7:0] d);
    return (DATA_MODE == 4) ? {d[7:4], 4'h0} : d;
  endfunction

  assign tmr_zero = (tmr_q == '0);
  // Clear (0x01) and Home (0x02/0x03) need the long execution wait.
  assign is_clear = !cur_q[8] && (cur_q[7:2] == 6'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      beat_q  <= 1'b0;
      cur_q   <= '0;
      lcd_q   <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      beat_q  <= beat_d;
      cur_q   <= cur_d;
      lcd_q   <= lcd_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    beat_d  = beat_q;
    cur_d   = cur_q;
    lcd_d   = lcd_q;
    rs_d    = rs_q;
    en_d    = en_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          cur_d   = head;
          rs_d    = head[8];
          lcd_d   = first_beat(head[7:0]);
          beat_d  = 1'b0;
          tmr_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          en_d    = 1'b1;
          tmr_d   = EN_LD;
          state_d = ST_EN_HI;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_EN_HI: begin
        if (tmr_zero) begin
          en_d    = 1'b0;
          tmr_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          if (DATA_MODE == 4 && !beat_q) begin
            beat_d  = 1'b1;
            lcd_d   = {cur_q[3:0], 4'h0};
            tmr_d   = SETUP_LD;
            state_d = ST_SETUP;
          end else begin
            tmr_d   = is_clear ? CLEAR_LD : EXEC_LD;
            state_d = ST_WAIT;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) state_d = ST_IDLE;  // counter is already 0 for IDLE
        else          tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign LCD       = lcd_q;
  assign lcdRS     = rs_q;
  assign lcdRW     = 1'b0;
  assign lcdEn     = en_q;
  assign host.busy = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_lcd_if_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_if_ctrl -- self-checking bench for lcd_if_ctrl.
//
// Two instances (8-bit and 4-bit mode) run side by side. A timeline model
// describes each word as a fixed waveform measured from the cycle it is
// popped: beats of (setup, enable, hold) followed by an execution wait, then
// one idle cycle in which the next word may be popped. Every cycle all DUT
// outputs are compared with that model; directed scenarios add literal
// expectations for pulse widths, gaps, busy time and FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_lcd_if_ctrl;
  localparam int S     = 2;
  localparam int E     = 4;
  localparam int H     = 2;
  localparam int XC    = 20;
  localparam int CC    = 100;
  localparam int DEPTH = 4;
  localparam int P     = S + E + H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_if_ctrl_if #(.FIFO_DEPTH(DEPTH)) h8 ();
  lcd_if_ctrl_if #(.FIFO_DEPTH(DEPTH)) h4 ();

  logic [7:0] lcd8, lcd4;
  logic       rs8, rs4, rw8, rw4, en8, en4;

  lcd_if_ctrl #(.DATA_MODE(8), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .EN_CYCLES(E),
                .HOLD_CYCLES(H), .EXEC_CYCLES(XC), .CLEAR_CYCLES(CC)) u8 (
    .clk(clk), .reset(reset), .host(h8),
    .LCD(lcd8), .lcdRS(rs8), .lcdRW(rw8), .lcdEn(en8));

  lcd_if_ctrl #(.DATA_MODE(4), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .EN_CYCLES(E),
                .HOLD_CYCLES(H), .EXEC_CYCLES(XC), .CLEAR_CYCLES(CC)) u4 (
    .clk(clk), .reset(reset), .host(h4),
    .LCD(lcd4), .lcdRS(rs4), .lcdRW(rw4), .lcdEn(en4));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: index 0 = 8-bit instance, 1 = 4-bit instance.
  logic [8:0] mq [2][$];       // queued words {rs, data}
  bit         act [2];         // a word has been popped since reset
  logic [8:0] cur [2];         // most recently popped word
  int         t   [2];         // cycles since that pop (saturates at dur)

  // Observation statistics for directed scenarios.
  int         pulses [2], hi_cyc [2], busy_cyc [2], gap [2], low_run [2];
  logic       prev_en [2];
  logic [7:0] plog [2][$];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total_cnt++;
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
  endtask

  function automatic int beats(input int m);
    return (m == 0) ? 1 : 2;
  endfunction

  function automatic int dur(input int m);
    bit clr = (cur[m][8] == 1'b0) && (cur[m][7:2] == 6'b0);
    return beats(m) * P + (clr ? CC : XC);
  endfunction

  function automatic logic [7:0] beat_val(input int m, input int b);
    if (m == 0) return cur[m][7:0];
    return (b == 0) ? {cur[m][7:4], 4'h0} : {cur[m][3:0], 4'h0};
  endfunction

  task automatic drive(input int m, input bit v, input bit rs, input logic [7:0] d);
    if (m == 0) begin h8.wr_valid = v; h8.wr_rs = rs; h8.wr_data = d; end
    else        begin h4.wr_valid = v; h4.wr_rs = rs; h4.wr_data = d; end
  endtask

  // Advance the model across one rising edge using the inputs on the bus.
  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      int         sz;
      bit         idle, v;
      logic [8:0] w;
      if (m == 0) begin v = h8.wr_valid; w = {h8.wr_rs, h8.wr_data}; end
      else        begin v = h4.wr_valid; w = {h4.wr_rs, h4.wr_data}; end
      if (!reset) begin
        mq[m].delete();
        act[m] = 1'b0;
        cur[m] = '0;
        t[m]   = 0;
      end else begin
        sz   = mq[m].size();
        idle = !act[m] || (t[m] >= dur(m));
        if (idle && sz != 0) begin
          cur[m] = mq[m].pop_front();
          act[m] = 1'b1;
          t[m]   = 0;
        end else if (act[m] && t[m] < dur(m)) begin
          t[m]++;
        end
        if (v && sz < DEPTH) mq[m].push_back(w);
      end
    end
  endtask

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      pulses[m] = 0; hi_cyc[m] = 0; busy_cyc[m] = 0; gap[m] = -1; low_run[m] = 0;
      prev_en[m] = 1'b0;
      plog[m].delete();
    end
  endtask

  // Compare every output of both instances with the model for this cycle.
  task automatic check_cycle();
    logic [7:0] a_lcd, e_lcd;
    logic       a_rs, a_rw, a_en, a_busy, a_rdy, e_rs, e_en, e_busy;
    logic [2:0] a_cnt;
    int         sz, b, r;
    string      pfx;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        a_lcd = lcd8; a_rs = rs8; a_rw = rw8; a_en = en8;
        a_busy = h8.busy; a_rdy = h8.wr_ready; a_cnt = h8.fifo_count; pfx = "m8";
      end else begin
        a_lcd = lcd4; a_rs = rs4; a_rw = rw4; a_en = en4;
        a_busy = h4.busy; a_rdy = h4.wr_ready; a_cnt = h4.fifo_count; pfx = "m4";
      end
      sz = mq[m].size();
      if (!act[m]) begin
        e_lcd = 8'h00; e_rs = 1'b0; e_en = 1'b0;
      end else if (t[m] < beats(m) * P) begin
        b = t[m] / P;
        r = t[m] % P;
        e_en  = (r >= S) && (r < S + E);
        e_lcd = beat_val(m, b);
        e_rs  = cur[m][8];
      end else begin
        e_en  = 1'b0;
        e_lcd = beat_val(m, beats(m) - 1);
        e_rs  = cur[m][8];
      end
      e_busy = (act[m] && t[m] < dur(m)) || (sz != 0);
      check({pfx, "_lcdEn"},      a_en,   e_en);
      check({pfx, "_LCD"},        a_lcd,  e_lcd);
      check({pfx, "_lcdRS"},      a_rs,   e_rs);
      check({pfx, "_lcdRW"},      a_rw,   0);
      check({pfx, "_busy"},       a_busy, e_busy);
      check({pfx, "_fifo_count"}, a_cnt,  sz);
      check({pfx, "_wr_ready"},   a_rdy,  (sz < DEPTH));

      if (a_en) begin
        hi_cyc[m]++;
        if (!prev_en[m]) begin
          if (pulses[m] > 0) gap[m] = low_run[m];
          pulses[m]++;
          plog[m].push_back(a_lcd);
        end
        low_run[m] = 0;
      end else begin
        low_run[m]++;
      end
      if (a_busy) busy_cyc[m]++;
      prev_en[m] = a_en;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((h8.busy || h4.busy) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_timeout", {h8.busy, h4.busy}, 2'b00);
  endtask

  task automatic gap_test(input bit rs, input logic [7:0] d, input int exp_gap, input string name);
    clear_stats();
    drive(0, 1'b1, rs, d);
    step();
    drive(0, 1'b1, 1'b1, 8'h42);
    step();
    drive(0, 1'b0, 1'b0, 8'h00);
    drain(1000);
    check({name, "_pulses"}, pulses[0], 2);
    check({name, "_gap"},    gap[0],    exp_gap);
  endtask

  initial begin
    int acc, n, pct;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; cur[m] = '0; t[m] = 0; end
    clear_stats();

    // Reset values, before any clock edge.
    #1;
    check("rst_lcdEn",    en8, 0);
    check("rst_LCD",      lcd8, 8'h00);
    check("rst_lcdRS",    rs8, 0);
    check("rst_lcdRW",    rw8, 0);
    check("rst_busy",     h8.busy, 0);
    check("rst_wr_ready", h8.wr_ready, 1);
    check("rst_count",    h8.fifo_count, 0);
    check("rst_LCD4",     lcd4, 8'h00);
    repeat (3) step();
    reset = 1'b1;

    // First push right after release; single word in each mode.
    clear_stats();
    drive(0, 1'b1, 1'b1, 8'h41);
    drive(1, 1'b1, 1'b0, 8'h28);
    step();
    check("first_push_cnt8", h8.fifo_count, 1);
    check("first_push_cnt4", h4.fifo_count, 1);
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    drain(1000);
    check("w41_pulses",   pulses[0], 1);
    check("w41_en_high",  hi_cyc[0], E);
    check("w41_lcd",      plog[0][0], 8'h41);
    check("w41_busy_cyc", busy_cyc[0], 29);
    check("w28_pulses",   pulses[1], 2);
    check("w28_en_high",  hi_cyc[1], 2 * E);
    check("w28_beat1",    plog[1][0], 8'h20);
    check("w28_beat2",    plog[1][1], 8'h80);
    check("w28_busy_cyc", busy_cyc[1], 37);

    // Clear/Home use the long wait; the same byte as data does not.
    gap_test(1'b0, 8'h01, H + CC + 1 + S, "clear");
    gap_test(1'b0, 8'h02, H + CC + 1 + S, "home");
    gap_test(1'b1, 8'h01, H + XC + 1 + S, "data01");

    // Six back-to-back pushes, then a refused push on the pop cycle.
    clear_stats();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 1'b1, 8'(8'h30 + i));
      if (h8.wr_ready) acc++;
      step();
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    repeat (24) step();
    check("full_count",  h8.fifo_count, 4);
    check("full_ready",  h8.wr_ready, 0);
    drive(0, 1'b1, 1'b1, 8'h99);
    step();
    check("pushpop_count", h8.fifo_count, 3);
    drive(0, 1'b0, 1'b0, 8'h00);
    drain(2000);
    check("burst_accepted", acc, 5);
    check("burst_pulses",   plog[0].size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("burst_order%0d", i), plog[0][i], 8'(8'h30 + i));

    // Randomized traffic: heavy phase keeps the FIFO full, light phase drains.
    for (int k = 0; k < 4000; k++) begin
      pct = (k < 2000) ? 20 : 3;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 99) < pct)
          drive(m, 1'b1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255)));
        else
          drive(m, 1'b0, 1'b0, 8'h00);
      end
      step();
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    drain(3000);

    // Reset during the enable pulse of the second of three queued words.
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b1, 8'(8'h51 + i));
      step();
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    n = 0;
    while (!(pulses[0] == 2 && en8) && n < 300) begin
      step();
      n++;
    end
    check("second_pulse_reached", {pulses[0][1:0], en8}, 3'b101);
    reset = 1'b0;
    #1;
    check("mid_rst_lcdEn", en8, 0);
    check("mid_rst_LCD",   lcd8, 8'h00);
    check("mid_rst_count", h8.fifo_count, 0);
    check("mid_rst_busy",  h8.busy, 0);
    check("mid_rst_ready", h8.wr_ready, 1);
    repeat (2) step();
    reset = 1'b1;
    clear_stats();
    repeat (100) step();
    check("post_rst_pulses8", pulses[0], 0);
    check("post_rst_pulses4", pulses[1], 0);
    drive(0, 1'b1, 1'b1, 8'h55);
    step();
    check("post_rst_push", h8.fifo_count, 1);
    drive(0, 1'b0, 1'b0, 8'h00);
    drain(1000);
    check("post_rst_lcd", plog[0][0], 8'h55);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/lcd_if_ctrl.md
LCD_IF_CTRL -- requirements
Module: lcd_if_ctrl

Interface
REQ-001 Parameter DATA_MODE, 8, LCD bus mode: 8 = 8-bit transfers, 4 = 4-bit (two nibbles per word); other values illegal.
REQ-002 Parameter FIFO_DEPTH, 8, command/data FIFO entries; power of 2, >= 2.
REQ-003 Parameter SETUP_CYCLES, 2, clk cycles lcdRS/LCD stable before lcdEn rises; >= 1.
REQ-004 Parameter EN_CYCLES, 12, clk cycles lcdEn held high; >= 1.
REQ-005 Parameter HOLD_CYCLES, 2, clk cycles lcdRS/LCD held after lcdEn falls; >= 1.
REQ-006 Parameter EXEC_CYCLES, 2000, wait after a complete word before the next transfer.
REQ-007 Parameter CLEAR_CYCLES, 80000, wait used instead of EXEC_CYCLES after a Clear or Home command.
REQ-008 clk  input  1  single system clock; all logic on rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-010 wr_valid  input  1  host presents a word.
REQ-011 wr_ready  output  1  FIFO can accept a word this cycle.
REQ-012 wr_rs  input  1  0 = instruction, 1 = display data.
REQ-013 wr_data  input  8  word to write.
REQ-014 busy  output  1  FIFO non-empty or transfer/wait in progress.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 LCD  output  8  LCD data bus.
REQ-017 lcdRS  output  1  LCD register select.
REQ-018 lcdRW  output  1  LCD read/write; always 0 (write-only).
REQ-019 lcdEn  output  1  LCD enable strobe.

Function
REQ-020 A word {wr_rs, wr_data} SHALL be pushed on a rising edge where wr_valid and wr_ready are both 1.
REQ-021 wr_ready SHALL equal (fifo_count < FIFO_DEPTH), from registered count only; a same-cycle pop does not make a full FIFO ready.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 wr_valid with wr_ready = 0 SHALL be ignored; FIFO contents and count unchanged.
REQ-024 States: IDLE, SETUP, EN_HI, HOLD, WAIT; one down-counter, wide enough for max(CLEAR_CYCLES, EXEC_CYCLES), times every state.
REQ-025 IDLE: when FIFO non-empty, pop the head word on that edge, drive lcdRS/LCD with the first beat, go to SETUP.
REQ-026 SETUP lasts SETUP_CYCLES cycles, lcdEn = 0; then EN_HI.
REQ-027 EN_HI lasts EN_CYCLES cycles, lcdEn = 1; then HOLD with lcdEn = 0.
REQ-028 HOLD lasts HOLD_CYCLES cycles, lcdRS/LCD unchanged; then WAIT, or SETUP for the second nibble in 4-bit mode.
REQ-029 8-bit mode: LCD = wr_data for the single beat.
REQ-030 4-bit mode: beat 1 LCD[7:4] = data[7:4], beat 2 LCD[7:4] = data[3:0]; LCD[3:0] = 0 both beats; lcdRS same on both.
REQ-031 WAIT lasts CLEAR_CYCLES if rs = 0 and data[7:2] = 000000 (Clear 0x01, Home 0x02/0x03), else EXEC_CYCLES; then IDLE.
REQ-032 LCD and lcdRS SHALL hold the last beat's values through WAIT and IDLE until the next pop.
REQ-033 busy = (state != IDLE) or (fifo_count != 0).
REQ-034 No lcdEn glitch: lcdEn changes only on state transitions, registered output.
REQ-035 Host pushes during a transfer SHALL queue without disturbing the transfer in progress.

Reset
REQ-036 reset = 0 SHALL immediately force state IDLE, counter 0, FIFO empty (pointers and count 0), LCD = 0x00, lcdRS = 0, lcdRW = 0, lcdEn = 0, busy = 0, wr_ready = 1.
REQ-037 Reset asserted mid-transfer SHALL abandon the word and all queued words; lcdEn drops asynchronously.
REQ-038 After reset deasserts, the first push is accepted on the next rising edge.

Verification (SETUP=2, EN=4, HOLD=2, EXEC=20, CLEAR=100, FIFO_DEPTH=4)
REQ-039 8-bit, push rs=1 data=0x41 into idle block -> one lcdEn pulse 4 cycles high, LCD=0x41, lcdRS=1 from 2 cycles before rise to 2 cycles after fall, busy clears 20 cycles after HOLD ends.
REQ-040 4-bit, push rs=0 data=0x28 -> two lcdEn pulses, LCD=0x20 then 0x80, lcdRS=0, WAIT = 20 cycles.
REQ-041 Push rs=0 data=0x01 then rs=1 data=0x42 -> 100-cycle gap after first word's HOLD before second SETUP; 0x02 likewise; rs=1 data=0x01 uses 20.
REQ-042 Push 6 words back-to-back with wr_valid held -> wr_ready drops when fifo_count reaches 4; only 5 words accepted (one popped meanwhile); all accepted words appear on LCD in order.
REQ-043 Fill FIFO to 4, then push and pop in same cycle -> push refused, fifo_count 3 next cycle.
REQ-044 Assert reset during EN_HI of the second of 3 queued words -> lcdEn 0 and LCD 0x00 immediately, fifo_count 0; after release no further lcdEn pulses until a new push.
